// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel registered mux family.
// Holds the mode encodings and the modular index increment used for the arbitration pointer.
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at ptr, ptr+1, ...
// (wrapping mod N) and reports the winner both one-hot and encoded.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] grant_idx
);

   logic            found_s;
   logic [SELW-1:0] cand_s;

   // Rotating priority search starting at ptr; first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      cand_s    = '0;
      for (int k = 0; k < N; k++) begin
         cand_s = SELW'((int'(ptr) + k) % N);
         if (!found_s && req[cand_s]) begin
            grant[cand_s] = 1'b1;
            grant_idx     = cand_s;
            found_s       = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with valid/ready on every port, selectable fixed-select or
// round-robin arbitration, and a tag naming the channel that supplied each output beat.
module mux_n_rr
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SELW-1:0]    S,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_ch,
   input  logic               out_ready
);

   logic [N-1:0]     arb_grant_s;
   logic [SELW-1:0]  arb_idx_s;
   logic [N-1:0]     grant_s;
   logic [SELW-1:0]  grant_idx_s;
   logic             sel_in_range_s;
   logic             load_s;
   logic             xfer_s;

   logic             out_valid_r;
   logic [WIDTH-1:0] out_data_r;
   logic [SELW-1:0]  out_ch_r;
   logic [SELW-1:0]  ptr_r;

   rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
      .req       (in_valid),
      .ptr       (ptr_r),
      .grant     (arb_grant_s),
      .grant_idx (arb_idx_s)
   );

   assign sel_in_range_s = (int'(S) < N);
   // The output slot can take a beat when empty or when its beat drains this same cycle.
   assign load_s   = !out_valid_r || out_ready;
   assign xfer_s   = !rst && load_s && (|grant_s);
   assign in_ready = (rst || !load_s) ? '0 : grant_s;

   // Grant selection: fixed channel S in select mode, rotating priority otherwise.
   always_comb begin
      grant_s     = '0;
      grant_idx_s = '0;
      if (mode == MODE_RR) begin
         grant_s     = arb_grant_s;
         grant_idx_s = arb_idx_s;
      end else if (sel_in_range_s && in_valid[S]) begin
         grant_s[S]  = 1'b1;
         grant_idx_s = S;
      end else begin
         grant_s     = '0;
         grant_idx_s = '0;
      end
   end

   // Output register and arbitration pointer; data and tag hold when the slot empties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_ch_r    <= '0;
         ptr_r       <= '0;
      end else if (xfer_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= in_data[grant_idx_s*WIDTH +: WIDTH];
         out_ch_r    <= grant_idx_s;
         ptr_r       <= SELW'(wrap_inc(32'(grant_idx_s), N));
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_n_rr.sv
// Self-checking bench for mux_n_rr: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the output slot and round-robin pointer.
module tb_mux_n_rr;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               mode = 1'b0;
   logic [SELW-1:0]    S = '0;
   logic [N-1:0]       in_valid = '0;
   logic [N*WIDTH-1:0] in_data = '0;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_ch;
   logic               out_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   // model of the output slot and arbitration pointer
   bit              m_valid = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   int              m_ch = 0;
   int              m_ptr = 0;

   mux_n_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .clk(clk), .rst(rst), .mode(mode), .S(S),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic int model_grant();
      if (mode == 1'b0) begin
         if (int'(S) < N && in_valid[S]) return int'(S);
         return -1;
      end
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready();
      int g;
      g = model_grant();
      if (rst) return '0;
      if ((m_valid && !out_ready) || g < 0) return '0;
      return N'(1) << g;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
   endtask

   // advance one clock; model follows the transfer rules on the same edge
   task automatic tick();
      int  g;
      bit  load;
      g    = model_grant();
      load = !m_valid || out_ready;
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else if (load && g >= 0) begin
         m_valid = 1'b1;
         m_data  = in_data[g*WIDTH +: WIDTH];
         m_ch    = g;
         m_ptr   = (g + 1) % N;
      end else if (out_ready) m_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic set_counting_data();
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
   endtask

   task automatic test_reset();
      in_valid = 4'b1111; out_ready = 1'b1; set_counting_data();
      #2;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b d=%h ch=%0d, want 0/00/0", out_valid, out_data, out_ch);
      end
      n_cmp++;
      if (in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b want 0000", in_ready);
      end
      pulse_reset();
   endtask

   task automatic test_reset_mid_stall();
      logic [N-1:0] exp_r;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
      tick(); tick();
      n_cmp++;
      if (out_valid !== 1'b1 || m_valid !== 1'b1) begin
         n_err++;
         $display("FAIL stall_setup: got out_valid=%b want 1", out_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_mid_stall: got v=%b d=%h ch=%0d rdy=%b, want 0/00/0/0000",
                  out_valid, out_data, out_ch, in_ready);
      end
      #1 rst = 1'b0;
      model_reset();
      exp_r = 4'b0001;
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== exp_r) begin
         n_err++;
         $display("FAIL post_reset_ptr: got in_ready=%b want %b", in_ready, exp_r);
      end
   endtask

   task automatic test_sel_fixed();
      pulse_reset();
      mode = 1'b0; S = 2'd2; in_valid = 4'b1111; out_ready = 1'b1; set_counting_data();
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++;
         if (in_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL sel_in_ready: cycle %0d got %b want 0100", c, in_ready);
         end
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 8'h12 || out_ch !== 2'd2) begin
            n_err++;
            $display("FAIL sel_out: cycle %0d got v=%b d=%h ch=%0d want 1/12/2", c, out_valid, out_data, out_ch);
         end
      end
   endtask

   task automatic test_rr_fair();
      int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
      pulse_reset();
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; set_counting_data();
      for (int c = 0; c < 6; c++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || int'(out_ch) != exp_seq[c] || out_data !== WIDTH'(8'h10 + exp_seq[c])) begin
            n_err++;
            $display("FAIL rr_fair: beat %0d got v=%b ch=%0d d=%h want 1/%0d", c, out_valid, out_ch, out_data, exp_seq[c]);
         end
      end
   endtask

   task automatic test_rr_sparse();
      int exp_seq [3] = '{3, 0, 3};
      pulse_reset();
      mode = 1'b1; out_ready = 1'b1; set_counting_data();
      in_valid = 4'b0001;
      tick();
      in_valid = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (in_ready[2:1] !== 2'b00) begin
            n_err++;
            $display("FAIL rr_sparse_idle: beat %0d got in_ready=%b want x00x", c, in_ready);
         end
         tick();
         n_cmp++;
         if (int'(out_ch) != exp_seq[c] || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rr_sparse: beat %0d got ch=%0d v=%b want %0d/1", c, out_ch, out_valid, exp_seq[c]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] held_d;
      logic [SELW-1:0]  held_ch;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; set_counting_data();
      tick(); tick();
      out_ready = 1'b0;
      #1;
      held_d = out_data; held_ch = out_ch;
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_in_ready: cycle %0d got %b want 0000", c, in_ready);
         end
         tick();
         n_cmp++;
         if (out_data !== held_d || out_ch !== held_ch || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: cycle %0d got d=%h ch=%0d want d=%h ch=%0d", c, out_data, out_ch, held_d, held_ch);
         end
      end
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if (int'(out_ch) != (int'(held_ch) + 1) % N || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: got ch=%0d want %0d", out_ch, (int'(held_ch) + 1) % N);
      end
   endtask

   task automatic test_sel_nogrant();
      mode = 1'b0; S = 2'd2; in_valid = 4'b1111; out_ready = 1'b1; set_counting_data();
      tick();
      in_valid = 4'b1011;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL nogrant_in_ready: got %b want 0000", in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_ch !== 2'd2 || out_data !== 8'h12) begin
         n_err++;
         $display("FAIL nogrant_drain: got v=%b ch=%0d d=%h want 0/2/12", out_valid, out_ch, out_data);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         mode      = 1'($urandom_range(0, 1));
         S         = SELW'($urandom_range(0, N - 1));
         in_valid  = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         #1;
         n_cmp++;
         if (in_ready !== model_ready()) begin
            n_err++;
            $display("FAIL rand_in_ready: cycle %0d got %b want %b", c, in_ready, model_ready());
         end
         tick();
         n_cmp++;
         if (out_valid !== m_valid || (m_valid && (out_data !== m_data || int'(out_ch) != m_ch))) begin
            n_err++;
            $display("FAIL rand_out: cycle %0d got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                     c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_stall();
      test_sel_fixed();
      test_rr_fair();
      test_rr_sparse();
      test_backpressure();
      test_sel_nogrant();
      pulse_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_n_rr.md
# mux_n_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It succeeds the plain 2:1 select mux. It adds a selectable round-robin arbitration mode, a registered output with backpressure, and a tag reporting which channel produced each output beat. It sits between several producer streams and one consumer that must see one beat per cycle at most.

## Interface
Parameters:
- `WIDTH`, 8, data bits per channel
- `N`, 4, number of input channels (N >= 2)
- `SELW`, `$clog2(N)`, width of the select and channel-tag fields

Ports:
- `clk` input 1 — the single clock
- `rst` input 1 — reset, asynchronous and active-high
- `mode` input 1 — 0 = MODE_SEL (channel chosen by `S`), 1 = MODE_RR (round-robin)
- `S` input SELW — channel select, used in MODE_SEL only
- `in_valid` input N — bit i set when channel i offers a beat
- `in_data` input N*WIDTH — channel i occupies bits [i*WIDTH +: WIDTH]
- `in_ready` output N — bit i set when channel i's beat is accepted this cycle
- `out_valid` output 1 — the output register holds a beat
- `out_data` output WIDTH — payload of the held beat
- `out_ch` output SELW — index of the channel that supplied the held beat
- `out_ready` input 1 — the consumer accepts the held beat

## Operation
- Transfer on any port occurs when valid && ready are both high at a rising `clk` edge.
- `load = !out_valid || out_ready`. The output register may capture a new beat only when `load` is high.
- Grant rules. At most one grant bit is set per cycle. Grant is computed combinationally from the current inputs and from `ptr`.
  - MODE_SEL: grant channel `S` only if `in_valid[S]`. If `S >= N`, there is no grant.
  - MODE_RR: grant the first channel with `in_valid` set, searching ptr, ptr+1, … in order and wrapping mod N.
- `in_ready[i] = load && grant[i]`. `in_ready` never depends on `in_valid[j]` for j ≠ granted channel, except through the arbitration itself.
- On a transfer from channel g:
  - `out_data` <= that channel's data
  - `out_ch` <= g
  - `out_valid` <= 1
  - `ptr` <= (g+1) mod N. `ptr` updates in both modes.
- If `out_ready` is high and no grant occurs, `out_valid` <= 0. `out_data` and `out_ch` hold their last values.
- Stall: while `out_valid && !out_ready`, `out_data` and `out_ch` stay stable and all `in_ready` bits are 0.
- A change to `mode` or `S` affects only the next grant decision. A beat already held in the output register is unaffected.
- `ptr` does not advance when there is no transfer. An idle channel never consumes its turn.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0. `in_ready` = 0 while `rst` is asserted.
- Reset takes effect asynchronously. A beat held mid-stall is discarded. There is no transfer on the edge at which `rst` deasserts if `rst` is still high at that edge.
- Latency is 1 cycle: a beat accepted at edge k appears on `out_*` after edge k.
- Throughput is 1 beat per cycle with `out_ready` held high. Simultaneous drain and load in the same cycle are required (no bubble).
- Fairness in MODE_RR with all N channels valid: grant order is ptr, ptr+1, …, so each channel is served exactly once per N accepted beats.
- Wrap-around: granting channel N-1 sets `ptr` to 0.

## Structure
- Shared package `mux_pkg`:
  - `localparam MODE_SEL = 1'b0`, `MODE_RR = 1'b1`
  - `typedef logic [1:0] ...` is not needed; the package holds only the mode constants and a function `wrap_inc(idx, n)` that returns the index incremented mod n.
- Sub-module `rr_arbiter` (parameter N):
  - inputs: `req[N]`, `ptr[SELW]`
  - outputs: one-hot `grant[N]` and its encoded index
  - purely combinational
  - `mux_n_rr` owns `ptr` and the output register.

## Test plan
- Reset mid-stall. Hold `out_valid`=1, `out_ready`=0, then pulse `rst` between edges → `out_valid`, `out_data`, `out_ch` go to 0 immediately; `in_ready`=0.
- MODE_SEL, N=4, `S`=2, `in_valid`=4'b1111, `in_data` channel i = 8'h10+i, `out_ready`=1 → `out_data`=8'h12 and `out_ch`=2 every cycle; `in_ready`=4'b0100.
- MODE_RR, all valid, `out_ready`=1, from reset → `out_ch` sequence 0,1,2,3,0,1; one beat per cycle with no bubbles.
- MODE_RR, `in_valid`=4'b1001, `ptr`=1 → grants 3, then 0, then 3; channels 1 and 2 are never granted.
- Backpressure. Deassert `out_ready` for 3 cycles while `out_valid`=1 → `out_data` is stable; `in_ready`=0; no beat is lost or duplicated after `out_ready` returns.
- MODE_SEL with `S`=2 and `in_valid[2]`=0 while other channels are valid → no grant; `out_valid` drops to 0 after the held beat drains.
